jtag_seq: RTL and testbench

Parametrised JTAG command sequencer; successor to the fixed one-shot instruction/data loader.
- Accepts commands over a valid/ready interface and streams instruction and data words into the instruction FIFO and data FIFO.
- Kicks the shift engine with `work`/`op`, then tracks `busy` to completion before accepting the next command.
- Sits between the host/control logic and the JTAG shift engine plus its two FIFOs.

---
 rtl/jtag_pkg.sv | 26 ++
 rtl/jtag_seq_wdog.sv | 31 +++
 rtl/jtag_seq.sv | 171 +++++++++++++++++
 tb/tb_jtag_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the JTAG command sequencer.
// Contents:
//   state_type     - sequencer FSM states
//   cmd_mode       - command mode encoding (2'b11 is illegal and has no member)
//   ID_INSTRUCTION - IDCODE opcode for a 10-bit instruction register
package jtag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_IR,
        ST_WR_DR,
        ST_KICK,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } state_type;

    typedef enum logic [1:0] {
        MODE_IR    = 2'b00,
        MODE_DR    = 2'b01,
        MODE_IR_DR = 2'b10
    } cmd_mode;

    localparam logic [9:0] ID_INSTRUCTION = 10'h006;

endpackage

// File: rtl/jtag_seq_wdog.sv
// jtag_seq_wdog: busy watchdog counter for jtag_seq.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   run_i       - sequencer is waiting on busy
//   clr_i       - sequencer changes state this cycle; restart the count
//   expired_o   - TIMEOUT_CYCLES cycles spent in the current wait state
module jtag_seq_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = (run_i && !clr_i) ? cnt_q + CW'(1) : '0;
        expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/jtag_seq.sv
// jtag_seq: JTAG command sequencer feeding the instruction/data FIFOs and
// kicking the shift engine, then tracking busy until the command completes.
// Optional busy watchdog: define JTAG_SEQ_TIMEOUT_EN.
// Ports:
//   clk, rst_n                        - clock, synchronous active-low reset
//   cmd_valid/cmd_ready               - command handshake
//   cmd_mode, cmd_ir, cmd_len         - command fields (mode, IR value, DR word count)
//   din, din_valid/din_ready          - DR word stream
//   op, work, busy                    - shift engine start pulse / op select / activity
//   wdata_instruction, wr_instruction - instruction FIFO write port
//   full_instruction, usedw_instruction
//   wdata_data, wr_data               - data FIFO write port
//   full_data, usedw_data
//   done, err                         - completion / reject-or-abort pulses
module jtag_seq
    import jtag_pkg::*;
#(
    parameter int DATA_INSTRUCTION = 10,
    parameter int DATA_FIFO        = 8,
    parameter int FIFO_DEPTH       = 16,
    parameter int MAX_WORDS        = 16,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_mode,
    input  logic [DATA_INSTRUCTION-1:0]        cmd_ir,
    input  logic [$clog2(MAX_WORDS+1)-1:0]     cmd_len,
    input  logic [DATA_FIFO-1:0]               din,
    input  logic                               din_valid,
    output logic                               din_ready,
    output logic                               op,
    output logic                               work,
    input  logic                               busy,
    output logic [DATA_INSTRUCTION-1:0]        wdata_instruction,
    output logic                               wr_instruction,
    input  logic                               full_instruction,
    input  logic [$clog2(FIFO_DEPTH)-1:0]      usedw_instruction,
    output logic [DATA_FIFO-1:0]               wdata_data,
    output logic                               wr_data,
    input  logic                               full_data,
    input  logic [$clog2(FIFO_DEPTH)-1:0]      usedw_data,
    output logic                               done,
    output logic                               err
);

    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam int UW = $clog2(FIFO_DEPTH);

    state_type                   state_q, state_d;
    jtag_pkg::cmd_mode           mode_q, mode_d;
    logic [DATA_INSTRUCTION-1:0] ir_q, ir_d, wdata_ir_q, wdata_ir_d;
    logic [DATA_FIFO-1:0]        wdata_dr_q, wdata_dr_d;
    logic [LW-1:0]               rem_q, rem_d;
    logic                        op_q, op_d, err_q, err_d;
    logic                        wr_ir_q, wr_ir_d, wr_dr_q, wr_dr_d;
    logic                        illegal;

`ifdef JTAG_SEQ_TIMEOUT_EN
    logic wd_expired;
    logic unused_ok;
    assign unused_ok = ^usedw_instruction;

    jtag_seq_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_q == ST_WAIT_HI || state_q == ST_WAIT_LO),
        .clr_i     (state_d != state_q),
        .expired_o (wd_expired)
    );
`else
    logic unused_ok;
    assign unused_ok = ^{usedw_instruction, 32'(TIMEOUT_CYCLES)};
`endif

    // Two FIFO slots of headroom: one for the registered write already in
    // flight, one for the word accepted this cycle.
    assign din_ready = (state_q == ST_WR_DR) && (rem_q != '0) && !full_data &&
                       (usedw_data < UW'(FIFO_DEPTH - 2));
    assign cmd_ready = rst_n && (state_q == ST_IDLE);
    assign illegal   = (cmd_mode == 2'b11) || (cmd_len > LW'(MAX_WORDS)) ||
                       ((cmd_mode != MODE_IR) && (cmd_len == '0));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ir_d       = ir_q;
        rem_d      = rem_q;
        op_d       = op_q;
        err_d      = 1'b0;
        wr_ir_d    = 1'b0;
        wdata_ir_d = wdata_ir_q;
        wr_dr_d    = 1'b0;
        wdata_dr_d = wdata_dr_q;
        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_ready) begin
                mode_d = jtag_pkg::cmd_mode'(cmd_mode);
                ir_d   = cmd_ir;
                rem_d  = cmd_len;
                if (illegal) err_d   = 1'b1;
                else         state_d = (cmd_mode == MODE_DR) ? ST_WR_DR : ST_WR_IR;
            end
            ST_WR_IR: if (!full_instruction) begin
                wr_ir_d    = 1'b1;
                wdata_ir_d = ir_q;
                op_d       = 1'b0;
                state_d    = ST_KICK;
            end
            ST_WR_DR: begin
                if (din_ready && din_valid) begin
                    wr_dr_d    = 1'b1;
                    wdata_dr_d = din;
                    rem_d      = rem_q - LW'(1);
                end else if (rem_q == '0) begin
                    op_d    = 1'b1;
                    state_d = ST_KICK;
                end
            end
            // busy already high in the kick cycle counts as the acknowledgement
            ST_KICK:    state_d = busy ? ST_WAIT_LO : ST_WAIT_HI;
            ST_WAIT_HI: if (busy) state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (!busy) state_d = (mode_q == MODE_IR_DR && !op_q) ? ST_WR_DR : ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
`ifdef JTAG_SEQ_TIMEOUT_EN
        if (wd_expired) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_IR;
            ir_q       <= '0;
            rem_q      <= '0;
            op_q       <= 1'b0;
            err_q      <= 1'b0;
            wr_ir_q    <= 1'b0;
            wdata_ir_q <= '0;
            wr_dr_q    <= 1'b0;
            wdata_dr_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ir_q       <= ir_d;
            rem_q      <= rem_d;
            op_q       <= op_d;
            err_q      <= err_d;
            wr_ir_q    <= wr_ir_d;
            wdata_ir_q <= wdata_ir_d;
            wr_dr_q    <= wr_dr_d;
            wdata_dr_q <= wdata_dr_d;
        end
    end

    assign op                = op_q;
    assign work              = (state_q == ST_KICK);
    assign done              = (state_q == ST_DONE);
    assign err               = err_q;
    assign wr_instruction    = wr_ir_q;
    assign wdata_instruction = wdata_ir_q;
    assign wr_data           = wr_dr_q;
    assign wdata_data        = wdata_dr_q;

endmodule

// File: tb/tb_jtag_seq.sv
// tb_jtag_seq: self-checking bench for jtag_seq with a behavioural shift
// engine, a DR word source and a command-level reference model.
module tb_jtag_seq;

    localparam int DI = 10, DF = 8, FD = 16, MW = 16, TO = 8;
    localparam int LW = $clog2(MW + 1), UW = $clog2(FD);

    logic clk = 0, rst_n = 0;
    logic cmd_valid = 0, cmd_ready;
    logic [1:0] cmd_mode = 0;
    logic [DI-1:0] cmd_ir = 0;
    logic [LW-1:0] cmd_len = 0;
    logic [DF-1:0] din = 0;
    logic din_valid = 0, din_ready;
    logic op, work, busy = 0;
    logic [DI-1:0] wdata_instruction;
    logic wr_instruction, full_instruction = 0;
    logic [UW-1:0] usedw_instruction = 0;
    logic [DF-1:0] wdata_data;
    logic wr_data, full_data = 0;
    logic [UW-1:0] usedw_data = 0;
    logic done, err;

    always #5 clk = ~clk;

    jtag_seq #(.DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .FIFO_DEPTH(FD),
               .MAX_WORDS(MW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .op(op), .work(work), .busy(busy),
        .wdata_instruction(wdata_instruction), .wr_instruction(wr_instruction),
        .full_instruction(full_instruction), .usedw_instruction(usedw_instruction),
        .wdata_data(wdata_data), .wr_data(wr_data), .full_data(full_data),
        .usedw_data(usedw_data), .done(done), .err(err)
    );

    int checks = 0, errors = 0;
    logic [DI-1:0] ir_log[$];
    logic [DF-1:0] dr_log[$], src_q[$];
    int dr_cyc[$];
    bit work_log[$];
    int n_done, n_err, done_cyc, err_cyc, work_cyc, fall_cyc, cyc = 0, viol = 0;
    bit fd_prev = 0, fi_prev = 0, busy_prev = 0;
    int hi_dly = 2, hi_len = 5;
    bit stuck = 0, gaps = 0, rnd_fifo = 0;

    // shift engine: busy rises hi_dly cycles after work, stays hi_len cycles
    always @(negedge clk) if (work === 1'b1 && !stuck) begin
        repeat (hi_dly) @(negedge clk);
        busy = 1;
        repeat (hi_len) @(negedge clk);
        busy = 0;
    end

    always @(negedge clk) if (rnd_fifo) begin
        usedw_data       = UW'($urandom_range(0, FD - 1));
        full_data        = ($urandom_range(0, 7) == 0);
        full_instruction = ($urandom_range(0, 3) == 0);
    end

    // DR word source; a word is consumed when valid and ready meet at the next edge
    always @(negedge clk) begin
        din_valid = (src_q.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
        din = din_valid ? src_q[0] : '0;
        #1;
        if (din_valid && din_ready) void'(src_q.pop_front());
    end

    always @(negedge clk) begin
        #1;
        cyc++;
        if (wr_instruction === 1'b1) begin ir_log.push_back(wdata_instruction); if (fi_prev) viol++; end
        if (wr_data === 1'b1) begin dr_log.push_back(wdata_data); dr_cyc.push_back(cyc); if (fd_prev) viol++; end
        if (work === 1'b1) begin work_log.push_back(op); work_cyc = cyc; end
        if (done === 1'b1) begin n_done++; done_cyc = cyc; end
        if (err === 1'b1) begin n_err++; err_cyc = cyc; end
        if (busy_prev && !busy) fall_cyc = cyc;
        busy_prev = busy;
        fd_prev = full_data;
        fi_prev = full_instruction;
    end

    task automatic clear_logs();
        ir_log.delete(); dr_log.delete(); dr_cyc.delete(); work_log.delete();
        n_done = 0; n_err = 0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [DI-1:0] ir, input logic [LW-1:0] len, output bit ok);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_mode = m; cmd_ir = ir; cmd_len = len;
        #1;
        while (!cmd_ready && t < 200) begin @(negedge clk); #1; t++; end
        ok = cmd_ready;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        int t = 0;
        while (n_done + n_err == 0 && t < budget) begin @(negedge clk); #2; t++; end
        ok = (n_done + n_err) != 0;
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({cmd_ready, din_ready, work, op, done, err, wr_instruction, wr_data, wdata_instruction, wdata_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {cmd_ready, din_ready, work, op, done, err, wr_instruction, wr_data, wdata_instruction, wdata_data});
        end
        @(negedge clk);
        rst_n = 1;
        #2;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, expected 1", cmd_ready); end
    endtask

    task automatic test_ir_only();
        bit ok1, ok2;
        clear_logs(); hi_dly = 2; hi_len = 5;
        issue(2'b00, 10'h006, '0, ok1);
        wait_end(100, ok2);
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL ir_only_timeout: accepted=%0b ended=%0b, expected 1 1", ok1, ok2); end
        checks++;
        if (ir_log.size() != 1 || ir_log[0] !== 10'h006) begin
            errors++; $display("FAIL ir_only_write: %0d writes first=%h, expected 1 write of 006", ir_log.size(), ir_log.size() ? ir_log[0] : '0);
        end
        checks++;
        if (work_log.size() != 1 || work_log[0] !== 1'b0) begin
            errors++; $display("FAIL ir_only_work: %0d kicks, expected 1 kick with op=0", work_log.size());
        end
        checks++;
        if (n_done != 1 || n_err != 0 || dr_log.size() != 0) begin
            errors++; $display("FAIL ir_only_result: done=%0d err=%0d dr=%0d, expected 1 0 0", n_done, n_err, dr_log.size());
        end
        checks++;
        if (done_cyc != fall_cyc + 1) begin
            errors++; $display("FAIL ir_only_done_timing: done at %0d, busy fell at %0d, expected one cycle later", done_cyc, fall_cyc);
        end
    endtask

    task automatic test_ir_dr();
        bit ok1, ok2;
        clear_logs(); gaps = 0; hi_dly = 1; hi_len = 3;
        src_q = '{8'hC4, 8'hC5, 8'hC6};
        issue(2'b10, 10'h0AB, LW'(3), ok1);
        wait_end(200, ok2);
        checks++;
        if (!(ok1 && ok2) || n_done != 1 || n_err != 0) begin
            errors++; $display("FAIL ir_dr_result: ok=%0b%0b done=%0d err=%0d, expected 11 1 0", ok1, ok2, n_done, n_err);
        end
        checks++;
        if (ir_log.size() != 1 || ir_log[0] !== 10'h0AB) begin
            errors++; $display("FAIL ir_dr_ir_write: %0d writes, expected 1 write of 0AB", ir_log.size());
        end
        checks++;
        if (work_log.size() != 2 || work_log[0] !== 1'b0 || work_log[1] !== 1'b1) begin
            errors++; $display("FAIL ir_dr_kicks: %0d kicks, expected op 0 then op 1", work_log.size());
        end
        checks++;
        if (dr_log.size() != 3 || dr_log[0] !== 8'hC4 || dr_log[1] !== 8'hC5 || dr_log[2] !== 8'hC6) begin
            errors++; $display("FAIL ir_dr_words: %0d words, expected C4 C5 C6", dr_log.size());
        end
        checks++;
        if (dr_cyc.size() != 3 || dr_cyc[2] - dr_cyc[0] != 2) begin
            errors++; $display("FAIL ir_dr_back_to_back: %0d writes not in consecutive cycles, expected 3 consecutive", dr_cyc.size());
        end
    endtask

    task automatic test_margin();
        bit ok1, ok2, rdy_seen = 0, moved = 0;
        int n0;
        logic [DF-1:0] exp_dr[$];
        clear_logs(); gaps = 0; viol = 0; hi_dly = 1; hi_len = 2;
        usedw_data = UW'(FD - 2);
        for (int i = 0; i < 16; i++) begin
            logic [DF-1:0] w = DF'($urandom);
            exp_dr.push_back(w); src_q.push_back(w);
        end
        issue(2'b01, '0, LW'(16), ok1);
        repeat (10) begin @(negedge clk); #2; if (din_ready) rdy_seen = 1; end
        checks++;
        if (dr_log.size() != 0 || rdy_seen) begin
            errors++; $display("FAIL margin_hold: writes=%0d ready_seen=%0b, expected 0 0", dr_log.size(), rdy_seen);
        end
        @(negedge clk); usedw_data = UW'(FD - 3);
        repeat (4) @(negedge clk);
        full_data = 1;
        #2;
        n0 = dr_log.size();
        repeat (5) begin @(negedge clk); #2; if (din_ready || dr_log.size() != n0) moved = 1; end
        checks++;
        if (moved || n0 == 0) begin
            errors++; $display("FAIL full_hold: moved=%0b words_before=%0d, expected 0 and nonzero", moved, n0);
        end
        @(negedge clk); full_data = 0;
        wait_end(300, ok2);
        checks++;
        if (!(ok1 && ok2) || n_done != 1 || work_log.size() != 1 || work_log[0] !== 1'b1) begin
            errors++; $display("FAIL margin_result: ok=%0b%0b done=%0d kicks=%0d, expected 11 1 1(op=1)", ok1, ok2, n_done, work_log.size());
        end
        checks++;
        if (dr_log.size() != exp_dr.size() || dr_log != exp_dr || viol != 0) begin
            errors++; $display("FAIL margin_words: %0d words viol=%0d, expected %0d matching words viol=0", dr_log.size(), viol, exp_dr.size());
        end
        @(negedge clk); usedw_data = 0;
    endtask

    task automatic test_illegal();
        logic [1:0] ms[3] = '{2'b11, 2'b01, 2'b01};
        logic [LW-1:0] ls[3] = '{LW'(2), LW'(0), LW'(20)};
        bit ok1, ok2;
        for (int k = 0; k < 3; k++) begin
            clear_logs();
            issue(ms[k], 10'h3FF, ls[k], ok1);
            wait_end(20, ok2);
            checks++;
            if (!(ok1 && ok2) || n_err != 1 || n_done != 0) begin
                errors++; $display("FAIL illegal_%0d_err: err=%0d done=%0d, expected 1 0", k, n_err, n_done);
            end
            checks++;
            if (ir_log.size() + dr_log.size() + work_log.size() != 0) begin
                errors++; $display("FAIL illegal_%0d_activity: ir=%0d dr=%0d kicks=%0d, expected none", k, ir_log.size(), dr_log.size(), work_log.size());
            end
            checks++;
            if (cmd_ready !== 1'b1) begin errors++; $display("FAIL illegal_%0d_ready: got %b, expected 1", k, cmd_ready); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2;
        int t = 0;
        clear_logs(); gaps = 0;
        src_q = '{8'h11, 8'h22};
        issue(2'b01, '0, LW'(4), ok1);
        while (dr_log.size() < 2 && t < 50) begin @(negedge clk); #2; t++; end
        @(negedge clk); rst_n = 0;
        @(negedge clk); #2;
        checks++;
        if ({cmd_ready, din_ready, work, op, done, err, wr_instruction, wr_data, wdata_instruction, wdata_data} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b, expected all zero",
                     {cmd_ready, din_ready, work, op, done, err, wr_instruction, wr_data, wdata_instruction, wdata_data});
        end
        src_q.push_back(8'h33); src_q.push_back(8'h44);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (dr_log.size() != 2 || n_done != 0) begin
            errors++; $display("FAIL reset_mid_writes: %0d words done=%0d, expected 2 0", dr_log.size(), n_done);
        end
        @(negedge clk); src_q.delete(); rst_n = 1;
        clear_logs();
        issue(2'b00, 10'h155, '0, ok1);
        wait_end(100, ok2);
        checks++;
        if (!(ok1 && ok2) || n_done != 1 || ir_log.size() != 1 || ir_log[0] !== 10'h155 || dr_log.size() != 0) begin
            errors++; $display("FAIL reset_mid_recover: ok=%0b%0b done=%0d ir=%0d dr=%0d, expected 11 1 1 0", ok1, ok2, n_done, ir_log.size(), dr_log.size());
        end
    endtask

    task automatic test_random();
        viol = 0; gaps = 1;
        @(negedge clk); rnd_fifo = 1;
        for (int n = 0; n < 25; n++) begin
            logic [1:0] m = 2'($urandom_range(0, 3));
            int len = (m == 2'b11) ? $urandom_range(0, 20) : (m == 2'b00) ? $urandom_range(0, MW) :
                      (m == 2'b01) ? $urandom_range(0, MW + 2) : $urandom_range(1, MW);
            logic [DI-1:0] ir = DI'($urandom);
            bit legal = (m != 2'b11) && (len <= MW) && !(m != 2'b00 && len == 0);
            logic [DI-1:0] exp_ir[$];
            logic [DF-1:0] exp_dr[$];
            bit exp_work[$];
            bit ok1, ok2;
            int bad = 0;
            clear_logs();
            hi_dly = $urandom_range(0, 3); hi_len = $urandom_range(1, 4);
            if (legal && m != 2'b01) begin exp_ir.push_back(ir); exp_work.push_back(1'b0); end
            if (legal && m != 2'b00) begin
                for (int i = 0; i < len; i++) begin
                    logic [DF-1:0] w = DF'($urandom);
                    exp_dr.push_back(w); src_q.push_back(w);
                end
                exp_work.push_back(1'b1);
            end
            issue(m, ir, LW'(len), ok1);
            wait_end(2000, ok2);
            if (ir_log.size() != exp_ir.size()) bad++; else foreach (exp_ir[i]) if (ir_log[i] !== exp_ir[i]) bad++;
            if (dr_log.size() != exp_dr.size()) bad++; else foreach (exp_dr[i]) if (dr_log[i] !== exp_dr[i]) bad++;
            if (work_log.size() != exp_work.size()) bad++; else foreach (exp_work[i]) if (work_log[i] !== exp_work[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL random_%0d_traffic: mode=%0d len=%0d ir=%0d dr=%0d kicks=%0d, expected ir=%0d dr=%0d kicks=%0d",
                                   n, m, len, ir_log.size(), dr_log.size(), work_log.size(), exp_ir.size(), exp_dr.size(), exp_work.size());
            end
            checks++;
            if (!(ok1 && ok2) || n_done != int'(legal) || n_err != int'(!legal)) begin
                errors++; $display("FAIL random_%0d_status: mode=%0d len=%0d done=%0d err=%0d, expected done=%0d err=%0d",
                                   n, m, len, n_done, n_err, legal, !legal);
            end
        end
        @(negedge clk); rnd_fifo = 0; usedw_data = 0; full_data = 0; full_instruction = 0;
        checks++;
        if (viol != 0) begin errors++; $display("FAIL write_while_full: %0d writes, expected 0", viol); end
    endtask

`ifdef JTAG_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok1, ok2;
        clear_logs(); stuck = 1;
        issue(2'b00, 10'h006, '0, ok1);
        wait_end(100, ok2);
        checks++;
        if (!(ok1 && ok2) || n_err != 1 || n_done != 0) begin
            errors++; $display("FAIL timeout_err: err=%0d done=%0d, expected 1 0", n_err, n_done);
        end
        checks++;
        if (err_cyc - work_cyc < TO || err_cyc - work_cyc > TO + 1) begin
            errors++; $display("FAIL timeout_delay: err %0d cycles after work, expected %0d..%0d", err_cyc - work_cyc, TO, TO + 1);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle: cmd_ready=%b, expected 1", cmd_ready); end
        stuck = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_ir_only();
        test_ir_dr();
        test_margin();
        test_illegal();
        test_reset_mid();
        test_random();
`ifdef JTAG_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
